// File: rtl/lenet_accelerator.sv
// LeNet-style inference engine: conv/pool/conv/pool/conv/fc on one shared MAC,
// one multiply-accumulate (or one pooling window) per cycle, looping forever.
module lenet_accelerator #(
    parameter int bitwidth = 32
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [27:0][27:0][bitwidth-1:0]           image,
    input  logic [1:0][4:0][4:0][bitwidth-1:0]        conv1_kernel,
    input  logic [1:0][1:0][4:0][4:0][bitwidth-1:0]   conv2_kernel,
    input  logic [9:0][1:0][4:0][4:0][bitwidth-1:0]   conv3_kernel,
    input  logic [9:0][9:0][bitwidth-1:0]             connect_matrix,
    output logic [9:0][bitwidth-1:0]                  output_vector,
    output logic                                      out_valid
);
    typedef logic signed [bitwidth-1:0] word_t;
    typedef enum logic [2:0] {CONV1, POOL1, CONV2, POOL2, CONV3, FC} state_t;

    state_t state, state_nxt;
    logic [3:0] oc, oc_max, oc_nxt, ic, ic_max, ic_nxt;
    logic [4:0] row, row_max, row_nxt, col, col_max, col_nxt;
    logic [2:0] ki, ki_max, ki_nxt, kj, kj_max, kj_nxt;
    logic       kj_end, ki_end, tap_last, col_end, row_end, pass_end, tap_first;

    word_t c1 [2][28][28];
    word_t p1 [2][14][14];
    word_t c2 [2][10][10];
    word_t p2 [2][5][5];
    word_t c3 [10];
    word_t fc_buf [10];
    word_t acc, mul_a, mul_b, prod, sum, relu, pmax, m01, m23;
    word_t w [4];

    logic [5:0] pr, pc, pr_off, pc_off;
    logic [3:0] r2, cc2;
    logic       pad;

    // Loop bounds (inclusive) of the nested counters for each layer.
    always_comb begin
        oc_max = '0; row_max = '0; col_max = '0; ic_max = '0; ki_max = '0; kj_max = '0;
        case (state)
            CONV1: begin oc_max = 4'd1; row_max = 5'd27; col_max = 5'd27; ki_max = 3'd4; kj_max = 3'd4; end
            POOL1: begin oc_max = 4'd1; row_max = 5'd13; col_max = 5'd13; end
            CONV2: begin oc_max = 4'd1; row_max = 5'd9; col_max = 5'd9; ic_max = 4'd1; ki_max = 3'd4; kj_max = 3'd4; end
            POOL2: begin oc_max = 4'd1; row_max = 5'd4; col_max = 5'd4; end
            CONV3: begin oc_max = 4'd9; ic_max = 4'd1; ki_max = 3'd4; kj_max = 3'd4; end
            FC:    begin oc_max = 4'd9; ic_max = 4'd9; end
            default: ;
        endcase
    end

    always_comb begin
        kj_end    = (kj == kj_max);
        ki_end    = kj_end && (ki == ki_max);
        tap_last  = ki_end && (ic == ic_max);
        col_end   = tap_last && (col == col_max);
        row_end   = col_end && (row == row_max);
        pass_end  = row_end && (oc == oc_max);
        tap_first = (kj == 3'd0) && (ki == 3'd0) && (ic == 4'd0);
        kj_nxt  = kj_end   ? 3'd0 : kj + 3'd1;
        ki_nxt  = ki_end   ? 3'd0 : (kj_end ? ki + 3'd1 : ki);
        ic_nxt  = tap_last ? 4'd0 : (ki_end ? ic + 4'd1 : ic);
        col_nxt = col_end  ? 5'd0 : (tap_last ? col + 5'd1 : col);
        row_nxt = row_end  ? 5'd0 : (col_end ? row + 5'd1 : row);
        oc_nxt  = pass_end ? 4'd0 : (row_end ? oc + 4'd1 : oc);
    end

    always_comb begin
        state_nxt = state;
        if (pass_end) begin
            case (state)
                CONV1:   state_nxt = POOL1;
                POOL1:   state_nxt = CONV2;
                CONV2:   state_nxt = POOL2;
                POOL2:   state_nxt = CONV3;
                CONV3:   state_nxt = FC;
                default: state_nxt = CONV1;
            endcase
        end
    end

    // Operand select; padded conv1 taps still spend their cycle multiplying zero.
    always_comb begin
        pr     = {1'b0, row} + {3'b0, ki};
        pc     = {1'b0, col} + {3'b0, kj};
        pr_off = pr - 6'd2;
        pc_off = pc - 6'd2;
        pad    = (pr < 6'd2) || (pr > 6'd29) || (pc < 6'd2) || (pc > 6'd29);
        r2     = row[3:0] + {1'b0, ki};
        cc2    = col[3:0] + {1'b0, kj};
        mul_a  = '0;
        mul_b  = '0;
        case (state)
            CONV1: begin
                mul_a = pad ? '0 : word_t'(image[pr_off[4:0]][pc_off[4:0]]);
                mul_b = word_t'(conv1_kernel[oc[0]][ki][kj]);
            end
            CONV2: begin
                mul_a = p1[ic[0]][r2][cc2];
                mul_b = word_t'(conv2_kernel[oc[0]][ic[0]][ki][kj]);
            end
            CONV3: begin
                mul_a = p2[ic[0]][ki][kj];
                mul_b = word_t'(conv3_kernel[oc][ic[0]][ki][kj]);
            end
            FC: begin
                mul_a = c3[ic];
                mul_b = word_t'(connect_matrix[oc][ic]);
            end
            default: ;
        endcase
        prod = mul_a * mul_b;
        sum  = (tap_first ? word_t'(0) : acc) + prod;
        relu = sum[bitwidth-1] ? word_t'(0) : sum;
    end

    always_comb begin
        if (state == POOL2) begin
            w[0] = c2[oc[0]][{row[2:0], 1'b0}][{col[2:0], 1'b0}];
            w[1] = c2[oc[0]][{row[2:0], 1'b0}][{col[2:0], 1'b1}];
            w[2] = c2[oc[0]][{row[2:0], 1'b1}][{col[2:0], 1'b0}];
            w[3] = c2[oc[0]][{row[2:0], 1'b1}][{col[2:0], 1'b1}];
        end else begin
            w[0] = c1[oc[0]][{row[3:0], 1'b0}][{col[3:0], 1'b0}];
            w[1] = c1[oc[0]][{row[3:0], 1'b0}][{col[3:0], 1'b1}];
            w[2] = c1[oc[0]][{row[3:0], 1'b1}][{col[3:0], 1'b0}];
            w[3] = c1[oc[0]][{row[3:0], 1'b1}][{col[3:0], 1'b1}];
        end
        m01  = (w[0] > w[1]) ? w[0] : w[1];
        m23  = (w[2] > w[3]) ? w[2] : w[3];
        pmax = (m01 > m23) ? m01 : m23;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CONV1;
            oc <= '0; row <= '0; col <= '0; ic <= '0; ki <= '0; kj <= '0;
            acc <= '0;
            output_vector <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            oc <= oc_nxt; row <= row_nxt; col <= col_nxt; ic <= ic_nxt; ki <= ki_nxt; kj <= kj_nxt;
            acc <= sum;
            out_valid <= (state == FC) && pass_end;
            if ((state == FC) && pass_end) begin
                for (int k = 0; k < 9; k++) output_vector[k] <= fc_buf[k];
                output_vector[9] <= sum;
            end
        end
    end

    // Feature maps are fully rewritten each pass before being read, so no reset.
    always_ff @(posedge clk) begin
        if (rst_n && tap_last) begin
            case (state)
                CONV1: c1[oc[0]][row][col] <= relu;
                POOL1: p1[oc[0]][row[3:0]][col[3:0]] <= pmax;
                CONV2: c2[oc[0]][row[3:0]][col[3:0]] <= relu;
                POOL2: p2[oc[0]][row[2:0]][col[2:0]] <= pmax;
                CONV3: c3[oc] <= relu;
                FC:    fc_buf[oc] <= sum;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lenet_accelerator.sv
// Randomized check of lenet_accelerator against a loop-based reference model,
// including reset state, mid-pass reset abort and first-result timing.
module tb_lenet_accelerator;
    logic clk = 1'b0;
    logic rst_n;
    logic [27:0][27:0][31:0]         image;
    logic [1:0][4:0][4:0][31:0]      conv1_kernel;
    logic [1:0][1:0][4:0][4:0][31:0] conv2_kernel;
    logic [9:0][1:0][4:0][4:0][31:0] conv3_kernel;
    logic [9:0][9:0][31:0]           connect_matrix;
    logic [9:0][31:0]                output_vector;
    logic                            out_valid;

    lenet_accelerator #(.bitwidth(32)) dut (
        .clk(clk), .rst_n(rst_n), .image(image),
        .conv1_kernel(conv1_kernel), .conv2_kernel(conv2_kernel),
        .conv3_kernel(conv3_kernel), .connect_matrix(connect_matrix),
        .output_vector(output_vector), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int img [28][28];
    int k1 [2][5][5];
    int k2 [2][2][5][5];
    int k3 [10][2][5][5];
    int fcw [10][10];
    int m_c1 [2][28][28];
    int m_p1 [2][14][14];
    int m_c2 [2][10][10];
    int m_p2 [2][5][5];
    int m_c3 [10];
    int exp_v [10];
    logic [9:0][31:0] exp_pk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int relu(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int rnd_small();
        return int'($urandom_range(0, 14)) - 7;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_model();
        int s;
        for (int o = 0; o < 2; o++)
            for (int r = 0; r < 28; r++)
                for (int c = 0; c < 28; c++) begin
                    s = 0;
                    for (int i = 0; i < 5; i++)
                        for (int j = 0; j < 5; j++)
                            if (r+i-2 >= 0 && r+i-2 < 28 && c+j-2 >= 0 && c+j-2 < 28)
                                s += img[r+i-2][c+j-2] * k1[o][i][j];
                    m_c1[o][r][c] = relu(s);
                end
        for (int o = 0; o < 2; o++)
            for (int r = 0; r < 14; r++)
                for (int c = 0; c < 14; c++)
                    m_p1[o][r][c] = max4(m_c1[o][2*r][2*c], m_c1[o][2*r][2*c+1],
                                         m_c1[o][2*r+1][2*c], m_c1[o][2*r+1][2*c+1]);
        for (int o = 0; o < 2; o++)
            for (int r = 0; r < 10; r++)
                for (int c = 0; c < 10; c++) begin
                    s = 0;
                    for (int n = 0; n < 2; n++)
                        for (int i = 0; i < 5; i++)
                            for (int j = 0; j < 5; j++)
                                s += m_p1[n][r+i][c+j] * k2[o][n][i][j];
                    m_c2[o][r][c] = relu(s);
                end
        for (int o = 0; o < 2; o++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    m_p2[o][r][c] = max4(m_c2[o][2*r][2*c], m_c2[o][2*r][2*c+1],
                                         m_c2[o][2*r+1][2*c], m_c2[o][2*r+1][2*c+1]);
        for (int o = 0; o < 10; o++) begin
            s = 0;
            for (int n = 0; n < 2; n++)
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        s += m_p2[n][i][j] * k3[o][n][i][j];
            m_c3[o] = relu(s);
        end
        for (int k = 0; k < 10; k++) begin
            s = 0;
            for (int m = 0; m < 10; m++) s += fcw[k][m] * m_c3[m];
            exp_v[k] = s;
            exp_pk[k] = s;
        end
    endtask

    initial begin
        int seen, n, dirty, done;
        rst_n = 1'b0;
        // Sparse, signed image so ReLU and pooling both see negatives and zeros.
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++) begin
                img[r][c] = ($urandom_range(0, 3) == 0) ? 0 : rnd_small();
                image[r][c] = img[r][c];
            end
        for (int o = 0; o < 2; o++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) begin
                    k1[o][i][j] = rnd_small();
                    conv1_kernel[o][i][j] = k1[o][i][j];
                    for (int n2 = 0; n2 < 2; n2++) begin
                        k2[o][n2][i][j] = rnd_small();
                        conv2_kernel[o][n2][i][j] = k2[o][n2][i][j];
                    end
                end
        for (int o = 0; o < 10; o++)
            for (int n2 = 0; n2 < 2; n2++)
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++) begin
                        k3[o][n2][i][j] = rnd_small();
                        conv3_kernel[o][n2][i][j] = k3[o][n2][i][j];
                    end
        // Full-range FC weights in some columns force 32-bit wrap-around.
        for (int k = 0; k < 10; k++)
            for (int m = 0; m < 10; m++) begin
                fcw[k][m] = (m % 3 == 0) ? int'($urandom) : rnd_small();
                connect_matrix[k][m] = fcw[k][m];
            end
        build_model();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_output_vector", output_vector, 0);

        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (20000) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("aborted_pass_no_valid", seen, 0);

        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_output_vector", output_vector, 0);

        @(negedge clk) rst_n = 1'b1;
        n = 0; dirty = 0; done = 0;
        while (!done && n < 60000) begin
            @(posedge clk); n++; #1;
            if (out_valid) done = 1;
            else if (output_vector != '0) dirty = 1;
        end
        chk("first_valid_edge", n, 50242);
        chk("vector_zero_before_valid", dirty, 0);
        for (int k = 0; k < 10; k++)
            chk($sformatf("output_vector[%0d]", k), output_vector[k], exp_pk[k]);

        @(posedge clk); #1;
        chk("valid_one_cycle", out_valid, 0);
        chk("vector_hold_1", output_vector, exp_pk);
        repeat (3) @(posedge clk);
        #1;
        chk("vector_hold_4", output_vector, exp_pk);
        chk("valid_stays_low", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lenet_accelerator.md
LENET_ACCELERATOR -- requirements
Module: lenet_accelerator

Interface
REQ-001 SHALL have parameter bitwidth, default 32, the width of every data word (signed two's complement).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port image, input, bitwidth x [27:0][27:0]: input image, indexed [row][col].
REQ-005 SHALL have port conv1_kernel, input, bitwidth x [1:0][4:0][4:0]: layer-1 kernels, indexed [out_ch][row][col].
REQ-006 SHALL have port conv2_kernel, input, bitwidth x [1:0][1:0][4:0][4:0]: layer-2 kernels, indexed [out_ch][in_ch][row][col].
REQ-007 SHALL have port conv3_kernel, input, bitwidth x [9:0][1:0][4:0][4:0]: layer-3 kernels, indexed [out_ch][in_ch][row][col].
REQ-008 SHALL have port connect_matrix, input, bitwidth x [9:0][9:0]: fully-connected weights, indexed [out][in].
REQ-009 SHALL have port output_vector, output, bitwidth x [9:0]: registered class scores.
REQ-010 SHALL have port out_valid, output, 1 bit: one-cycle pulse when output_vector is updated.

Function
REQ-011 SHALL compute conv1 as a 5x5 convolution with zero padding of 2, giving 2x28x28: c1[o][r][c] = sum over i,j of image[r+i-2][c+j-2]*conv1_kernel[o][i][j], with out-of-range pixels read as 0.
REQ-012 SHALL apply ReLU (negative becomes 0) to every conv1, conv2 and conv3 result, and not to the FC result.
REQ-013 SHALL reduce conv1 to pool1 (2x14x14) by 2x2 stride-2 max pooling: p1[o][r][c] = max of c1[o][2r..2r+1][2c..2c+1].
REQ-014 SHALL compute conv2 as a valid 5x5 convolution giving 2x10x10: c2[o][r][c] = sum over n,i,j of p1[n][r+i][c+j]*conv2_kernel[o][n][i][j].
REQ-015 SHALL reduce conv2 to pool2 (2x5x5) by 2x2 stride-2 max pooling.
REQ-016 SHALL compute conv3 as a valid 5x5 convolution giving 10x1x1: c3[o] = sum over n,i,j of p2[n][i][j]*conv3_kernel[o][n][i][j].
REQ-017 SHALL compute the FC layer as fc[k] = sum over m of connect_matrix[k][m]*c3[m].
REQ-018 SHALL use bitwidth-wide signed products and accumulators, truncating (wrapping) modulo 2^bitwidth, with no saturation or bias.
REQ-019 SHALL perform exactly one multiply-accumulate per cycle, with padded taps also taking one cycle each.
REQ-020 SHALL evaluate one 2x2 pooling window per cycle.
REQ-021 SHALL use FSM states CONV1 -> POOL1 -> CONV2 -> POOL2 -> CONV3 -> FC -> CONV1, looping continuously.
REQ-022 SHALL run the passes back-to-back, with the next pass starting in the cycle after the FC state ends.
REQ-023 SHALL have the following per-pass cycle counts: CONV1 39200, POOL1 392, CONV2 10000, POOL2 50, CONV3 500, FC 100, for a total of 50242 cycles.
REQ-024 SHALL write each output element in the cycle of its last tap or window.
REQ-025 SHALL register all 10 fc results into output_vector together at the end of the FC state, and pulse out_valid for exactly one cycle in that same cycle.
REQ-026 SHALL assert the first out_valid on the 50242nd rising edge after the first edge that samples rst_n high, with a period of 50242 thereafter.
REQ-027 SHALL hold output_vector unchanged between updates.
REQ-028 SHALL NOT snapshot the inputs; the inputs must be held stable for a whole pass, and changes during a pass give undefined results for that pass only.
REQ-029 SHALL store intermediate feature maps (c1, p1, c2, p2, c3) in internal registers or RAM and keep them invisible at the ports.

Reset
REQ-030 SHALL, while rst_n is low on a rising edge, clear output_vector to all 0, clear out_valid to 0, clear all counters, and set the FSM to CONV1 at tap 0.
REQ-031 SHALL, on reset asserted mid-pass, abort the pass without updating output_vector and restart from CONV1 once rst_n is high.
REQ-032 SHALL NOT require intermediate buffers to be cleared by reset, because every pass overwrites them before they are read.

Verification
REQ-033 SHALL pass the impulse test: image[0][0]=1, conv1_kernel[0][0][0]=1, conv2_kernel[0][0][0][0]=1, conv3_kernel[0][0][0][0]=1, connect_matrix = identity, all else 0 -> output_vector[0]=1, others 0, at the first out_valid (cycle 50242).
REQ-034 SHALL pass the all-zero test: all inputs 0 -> output_vector all 0, with out_valid pulsing every 50242 cycles.
REQ-035 SHALL pass the ReLU/max-pool test: image[0][0]=-1, image[1][1]=7, conv1_kernel[0][2][2]=1, the remaining kernels as in REQ-033, identity FC -> output_vector[0]=7.
REQ-036 SHALL pass the FC routing test: the impulse setup with connect_matrix[3][0]=5 and connect_matrix[0][0]=0 -> output_vector[3]=5, output_vector[0]=0.
REQ-037 SHALL pass the wrap test: the impulse setup with connect_matrix[0][0]=32'h40000000 and conv3_kernel[0][0][0][0]=4 -> output_vector[0]=0 (truncation).
REQ-038 SHALL pass the mid-pass reset test: rst_n pulled low at cycle 20000 -> output_vector stays 0 and the first out_valid occurs 50242 edges after reset release.
